// File: rtl/spi_display_scheduler.sv
// rtl/spi_display_scheduler.sv - MAX7219 init/command/refresh-frame scheduler for a shared SPI master
module spi_display_scheduler #(
    parameter int         NUM_DIGITS = 6,
    parameter logic [2:0] SCAN_LIMIT = 3'd5,
    parameter logic [3:0] INTENSITY  = 4'h8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    refresh_req,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    cmd_req,
    input  logic [15:0]             cmd_word,
    output logic                    cmd_ack,
    output logic                    m_cs,
    output logic [15:0]             m_word,
    input  logic                    m_ready,
    input  logic                    m_sent,
    output logic                    init_done,
    output logic                    busy,
    output logic                    refresh_done,
    output logic                    refresh_drop
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT_SENT, S_WAIT_READY} state_t;
    typedef enum logic [1:0] {SRC_INIT, SRC_CMD, SRC_FRAME} src_t;

    localparam logic [2:0] INIT_LAST  = 3'd4;
    localparam logic [2:0] FRAME_LAST = 3'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    src_t                    src_q, src_d;
    logic [2:0]              idx_q, idx_d;
    logic                    cs_q, cs_d;
    logic [15:0]             word_q, word_d;
    logic                    ack_q, ack_d;
    logic                    init_done_q, init_done_d;
    logic                    done_q, done_d;
    logic                    drop_q, drop_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    ready_ok;
    logic                    grant_frame;
    logic [2:0]              idx_nxt;
    logic [2:0]              seq_last;

    function automatic logic [15:0] init_word(input logic [2:0] k);
        case (k)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h09FF;
            3'd2:    init_word = {8'h0B, 5'b0, SCAN_LIMIT};
            3'd3:    init_word = {8'h0A, 4'b0, INTENSITY};
            default: init_word = 16'h0F00;
        endcase
    endfunction

    function automatic logic [15:0] frame_word(input logic [2:0]              k,
                                               input logic [4*NUM_DIGITS-1:0] dig,
                                               input logic [NUM_DIGITS-1:0]   dp);
        frame_word = {8'(k) + 8'd1, dp[k], 3'b000, dig[4*k +: 4]};
    endfunction

    // Follow-on words of a sequence; a command is always a single word
    function automatic logic [15:0] next_word(input src_t src, input logic [2:0] k,
                                              input logic [4*NUM_DIGITS-1:0] dig,
                                              input logic [NUM_DIGITS-1:0]   dp);
        case (src)
            SRC_INIT:  next_word = init_word(k);
            SRC_FRAME: next_word = frame_word(k, dig, dp);
            default:   next_word = 16'h0000;
        endcase
    endfunction

    // Index of the final word for the sequence currently on the wire
    always_comb begin
        case (src_q)
            SRC_INIT:  seq_last = INIT_LAST;
            SRC_FRAME: seq_last = FRAME_LAST;
            default:   seq_last = 3'd0;
        endcase
    end

    // State register; async reset forces chip select high immediately
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_INIT;
            src_q       <= SRC_INIT;
            idx_q       <= 3'd0;
            cs_q        <= 1'b1;
            word_q      <= 16'h0000;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            pend_q      <= 1'b0;
            snap_dig_q  <= '0;
            snap_dp_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            idx_q       <= idx_d;
            cs_q        <= cs_d;
            word_q      <= word_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            snap_dig_q  <= snap_dig_d;
            snap_dp_q   <= snap_dp_d;
        end
    end

    // Sequencing, arbitration and the one-deep refresh request queue
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        idx_d       = idx_q;
        cs_d        = cs_q;
        word_d      = word_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        done_d      = 1'b0;
        drop_d      = 1'b0;
        pend_d      = pend_q;
        snap_dig_d  = snap_dig_q;
        snap_dp_d   = snap_dp_q;
        grant_frame = 1'b0;
        ready_ok    = m_ready && !m_sent;
        idx_nxt     = idx_q + 3'd1;

        case (state_q)
            S_INIT: begin
                if (ready_ok) begin
                    src_d   = SRC_INIT;
                    idx_d   = 3'd0;
                    word_d  = init_word(3'd0);
                    cs_d    = 1'b0;
                    state_d = S_WAIT_SENT;
                end
            end
            S_IDLE: begin
                if (ready_ok) begin
                    if (cmd_req) begin
                        ack_d   = 1'b1;
                        src_d   = SRC_CMD;
                        idx_d   = 3'd0;
                        word_d  = cmd_word;
                        cs_d    = 1'b0;
                        state_d = S_WAIT_SENT;
                    end else if (pend_q) begin
                        grant_frame = 1'b1;
                        src_d       = SRC_FRAME;
                        idx_d       = 3'd0;
                        snap_dig_d  = digits;
                        snap_dp_d   = dp_mask;
                        word_d      = frame_word(3'd0, digits, dp_mask);
                        cs_d        = 1'b0;
                        state_d     = S_WAIT_SENT;
                    end
                end
            end
            S_WAIT_SENT: begin
                if (m_sent) begin
                    cs_d    = 1'b1;
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (ready_ok) begin
                    if (idx_q != seq_last) begin
                        idx_d   = idx_nxt;
                        word_d  = next_word(src_q, idx_nxt, snap_dig_q, snap_dp_q);
                        cs_d    = 1'b0;
                        state_d = S_WAIT_SENT;
                    end else begin
                        state_d = S_IDLE;
                        if (src_q == SRC_INIT)  init_done_d = 1'b1;
                        if (src_q == SRC_FRAME) done_d      = 1'b1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // A request arriving on the grant edge refills the slot the grant just freed
        if (refresh_req) begin
            if (pend_q && !grant_frame) drop_d = 1'b1;
            else                        pend_d = 1'b1;
        end else if (grant_frame) begin
            pend_d = 1'b0;
        end
    end

    assign cmd_ack      = ack_q;
    assign m_cs         = cs_q;
    assign m_word       = word_q;
    assign init_done    = init_done_q;
    assign busy         = (state_q != S_IDLE);
    assign refresh_done = done_q;
    assign refresh_drop = drop_q;

endmodule

// File: tb/tb_spi_display_scheduler.sv
// tb/tb_spi_display_scheduler.sv - self-checking bench for spi_display_scheduler
module tb_spi_display_scheduler;

    logic        clk;
    logic        res;
    logic        refresh_req;
    logic [23:0] digits;
    logic [5:0]  dp_mask;
    logic        cmd_req;
    logic [15:0] cmd_word;
    logic        cmd_ack;
    logic        m_cs;
    logic [15:0] m_word;
    logic        m_ready;
    logic        m_sent;
    logic        init_done;
    logic        busy;
    logic        refresh_done;
    logic        refresh_drop;

    spi_display_scheduler dut (
        .clk          (clk),
        .res          (res),
        .refresh_req  (refresh_req),
        .digits       (digits),
        .dp_mask      (dp_mask),
        .cmd_req      (cmd_req),
        .cmd_word     (cmd_word),
        .cmd_ack      (cmd_ack),
        .m_cs         (m_cs),
        .m_word       (m_word),
        .m_ready      (m_ready),
        .m_sent       (m_sent),
        .init_done    (init_done),
        .busy         (busy),
        .refresh_done (refresh_done),
        .refresh_drop (refresh_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_err    = 0;
    int          n_checks = 0;
    int          send_cyc = 66;
    logic [15:0] rx_q[$];
    logic [15:0] exp_q[$];
    int          rx_base  = 0;
    int          ack_cnt  = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    int          prot_err = 0;

    // Master model: idle-ready, takes a word when cs is low, reports sent after send_cyc
    int          mst_cnt;
    int          mst_phase;
    bit          mst_busy;
    logic [15:0] mst_word;
    always @(negedge clk) begin
        if (!res) begin
            m_ready  = 1'b1;
            m_sent   = 1'b0;
            mst_busy = 1'b0;
        end else if (!mst_busy) begin
            if (m_cs == 1'b0) begin
                rx_q.push_back(m_word);
                mst_word  = m_word;
                mst_busy  = 1'b1;
                m_ready   = 1'b0;
                mst_cnt   = send_cyc;
                mst_phase = 0;
            end
        end else begin
            case (mst_phase)
                0: begin
                    if (m_cs !== 1'b0 || m_word !== mst_word) prot_err++;
                    mst_cnt--;
                    if (mst_cnt <= 0) begin
                        m_sent    = 1'b1;
                        mst_phase = 1;
                    end
                end
                1: begin
                    m_sent    = 1'b0;
                    mst_cnt   = 2;
                    mst_phase = 2;
                end
                default: begin
                    mst_cnt--;
                    if (mst_cnt <= 0) begin
                        m_ready  = 1'b1;
                        mst_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (res) begin
            if (cmd_ack)      ack_cnt++;
            if (refresh_done) done_cnt++;
            if (refresh_drop) drop_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name, input int got, input int req);
        n_checks++;
        n_err++;
        $display("FAIL %s timeout: got %0d, required %0d", name, got, req);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while ((rx_q.size() - rx_base) < n && t < budget) begin
            step();
            t++;
        end
        if ((rx_q.size() - rx_base) < n) timeout("wait_rx", rx_q.size() - rx_base, n);
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_cnt < n && t < budget) begin
            step();
            t++;
        end
        if (done_cnt < n) timeout("wait_done", done_cnt, n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy || !m_ready) && t < budget) begin
            step();
            t++;
        end
        if (busy || !m_ready) timeout("wait_idle", int'(busy), 0);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, rx_q.size() - rx_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (rx_base + i < rx_q.size())
                check($sformatf("%s_w%0d", name, i), rx_q[rx_base + i], exp_q[i]);
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h09FF);
        exp_q.push_back(16'h0B05);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0F00);
    endtask

    // Reference: MAX7219 digit register address k+1, DP in bit 7, BCD in the low nibble
    function automatic logic [15:0] model_word(input int k, input logic [23:0] dig, input logic [5:0] dp);
        int d;
        int p;
        d = int'((dig >> (4 * k)) & 24'hF);
        p = int'((dp >> k) & 6'h1);
        return 16'((k + 1) * 256 + p * 128 + d);
    endfunction

    task automatic push_frame(input logic [23:0] dig, input logic [5:0] dp);
        for (int k = 0; k < 6; k++) exp_q.push_back(model_word(k, dig, dp));
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
    endtask

    typedef struct packed {
        logic [23:0]      dig;
        logic [5:0]       dp;
        logic [5:0][15:0] w;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int base_ack;
        int base_done;
        int base_drop;
        int mode;
        int t;
        logic [23:0] rdig;
        logic [5:0]  rdp;

        vecs[0] = '{dig: 24'h456789, dp: 6'b010100,
                    w: {16'h0604, 16'h0585, 16'h0406, 16'h0387, 16'h0208, 16'h0109}};
        vecs[1] = '{dig: 24'h000000, dp: 6'b000000,
                    w: {16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100}};
        vecs[2] = '{dig: 24'h999999, dp: 6'b111111,
                    w: {16'h0689, 16'h0589, 16'h0489, 16'h0389, 16'h0289, 16'h0189}};
        vecs[3] = '{dig: 24'h123450, dp: 6'b100001,
                    w: {16'h0681, 16'h0502, 16'h0403, 16'h0304, 16'h0205, 16'h0180}};

        res = 1'b0; refresh_req = 1'b0; cmd_req = 1'b0; cmd_word = 16'h0;
        digits = 24'h0; dp_mask = 6'h0;
        repeat (3) step();

        check("rst_m_cs", m_cs, 1);
        check("rst_m_word", m_word, 0);
        check("rst_cmd_ack", cmd_ack, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);
        check("rst_refresh_done", refresh_done, 0);
        check("rst_refresh_drop", refresh_drop, 0);

        // Init sequence with a slow master; refresh_req during init is only latched
        res = 1'b1;
        step();
        pulse_refresh();
        wait_rx(5, 3000);
        check("init_done_before_last", init_done, 0);
        t = 0;
        while (!init_done && t < 500) begin step(); t++; end
        check("init_done_set", init_done, 1);
        push_init();
        compare_stream("init");
        send_cyc = 8;
        push_frame(24'h0, 6'h0);
        wait_done(1, 1000);
        compare_stream("init_pending_frame");
        wait_idle(200);
        check("idle_busy", busy, 0);

        // Table-driven frames: grant latency and word contents
        for (int i = 0; i < 4; i++) begin
            wait_idle(200);
            digits = vecs[i].dig;
            dp_mask = vecs[i].dp;
            base_done = done_cnt;
            pulse_refresh();
            check($sformatf("v%0d_lat_pending", i), m_cs, 1);
            step();
            check($sformatf("v%0d_lat_grant", i), m_cs, 0);
            wait_done(base_done + 1, 1000);
            for (int k = 0; k < 6; k++) exp_q.push_back(vecs[i].w[k]);
            compare_stream($sformatf("v%0d", i));
            check($sformatf("v%0d_done_cnt", i), done_cnt - base_done, 1);
        end

        // Command and refresh on the same edge: command first, then the frame
        wait_idle(200);
        digits = vecs[0].dig; dp_mask = vecs[0].dp;
        base_ack = ack_cnt; base_done = done_cnt;
        cmd_word = 16'h0A0F; cmd_req = 1'b1; refresh_req = 1'b1;
        step();
        check("cmd_ack_same_edge", cmd_ack, 1);
        check("cmd_cs_same_edge", m_cs, 0);
        cmd_req = 1'b0; refresh_req = 1'b0;
        wait_done(base_done + 1, 1000);
        exp_q.push_back(16'h0A0F);
        for (int k = 0; k < 6; k++) exp_q.push_back(vecs[0].w[k]);
        compare_stream("cmd_then_frame");
        check("cmd_ack_cnt", ack_cnt - base_ack, 1);

        // Snapshot: inputs cleared after word 2 must not affect the frame
        wait_idle(200);
        base_done = done_cnt;
        pulse_refresh();
        wait_rx(3, 500);
        digits = 24'h0; dp_mask = 6'h0;
        wait_done(base_done + 1, 1000);
        for (int k = 0; k < 6; k++) exp_q.push_back(vecs[0].w[k]);
        compare_stream("snapshot");

        // Two requests during a frame: second one dropped, one extra frame
        wait_idle(200);
        digits = vecs[0].dig; dp_mask = vecs[0].dp;
        base_done = done_cnt; base_drop = drop_cnt;
        pulse_refresh();
        wait_rx(1, 500);
        pulse_refresh();
        step();
        pulse_refresh();
        wait_done(base_done + 2, 2000);
        repeat (60) step();
        check("drop_cnt", drop_cnt - base_drop, 1);
        check("double_done_cnt", done_cnt - base_done, 2);
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 6; k++) exp_q.push_back(vecs[0].w[k]);
        compare_stream("double");

        // Randomized commands/frames against the reference model
        for (int it = 0; it < 25; it++) begin
            wait_idle(300);
            send_cyc = int'($urandom_range(2, 12));
            mode = int'($urandom_range(0, 2));
            rdig = 24'($urandom);
            rdp  = 6'($urandom);
            digits = rdig; dp_mask = rdp;
            base_ack = ack_cnt; base_done = done_cnt;
            if (mode != 1) begin
                cmd_word = 16'($urandom);
                exp_q.push_back(cmd_word);
            end
            if (mode != 0) push_frame(rdig, rdp);
            cmd_req = (mode != 1);
            refresh_req = (mode != 0);
            step();
            refresh_req = 1'b0;
            t = 0;
            while (cmd_req && !cmd_ack && t < 500) begin step(); t++; end
            cmd_req = 1'b0;
            if (mode != 0) begin
                wait_rx((mode == 2) ? 2 : 1, 500);
                digits = 24'($urandom); dp_mask = 6'($urandom);
                wait_done(base_done + 1, 1500);
            end else begin
                wait_rx(1, 500);
                wait_idle(300);
            end
            compare_stream($sformatf("rnd%0d_m%0d", it, mode));
            check($sformatf("rnd%0d_ack", it), ack_cnt - base_ack, (mode != 1) ? 1 : 0);
            check($sformatf("rnd%0d_done", it), done_cnt - base_done, (mode != 0) ? 1 : 0);
        end

        // Reset mid-frame: cs released without a clock edge, then init replays
        wait_idle(300);
        send_cyc = 8;
        digits = vecs[0].dig; dp_mask = vecs[0].dp;
        pulse_refresh();
        wait_rx(3, 500);
        check("midrst_cs_low", m_cs, 0);
        #2;
        res = 1'b0;
        #1;
        check("midrst_cs", m_cs, 1);
        check("midrst_init_done", init_done, 0);
        check("midrst_busy", busy, 1);
        repeat (3) step();
        rx_base = rx_q.size();
        res = 1'b1;
        wait_rx(5, 1000);
        t = 0;
        while (!init_done && t < 200) begin step(); t++; end
        check("replay_init_done", init_done, 1);
        push_init();
        compare_stream("replay");
        repeat (40) step();
        check("replay_no_frame", rx_q.size() - rx_base, 0);

        check("cs_hold_violations", prot_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_display_scheduler.md
# spi_display_scheduler

Sequencer and arbiter that owns the single 16-bit SPI master driving the MAX7219 stopwatch display. After reset it issues the display init sequence, then grants the master either to one-shot command words (e.g. intensity changes) or to atomic 6-digit refresh frames built from the counter-chain digits. It sits between the stopwatch core (counter chain, lap/display control, 100 Hz tick) and the SPI master's `cs_in`/`word_in`/`report_ready`/`report_send` handshake.

## Interface
- `NUM_DIGITS`, 6: digits per refresh frame; MAX7219 digit addresses 1..NUM_DIGITS.
- `SCAN_LIMIT`, 3'd5: data byte of the scan-limit init word.
- `INTENSITY`, 4'h8: data byte of the intensity init word.

- `clk` in 1: system clock; single clock domain.
- `res` in 1: reset, asynchronous, active-low.
- `refresh_req` in 1: request one refresh frame; sampled every edge.
- `digits` in 4*NUM_DIGITS: BCD digits; digit k is at [4k+3:4k]; digit 0 = ces_0X.
- `dp_mask` in NUM_DIGITS: decimal-point bit per digit.
- `cmd_req` in 1: level; held high until `cmd_ack`.
- `cmd_word` in 16: command word; sampled on the `cmd_ack` edge.
- `cmd_ack` out 1: one-cycle pulse when the command is granted.
- `m_cs` out 1: to master `cs_in`; low = send.
- `m_word` out 16: to master `word_in`.
- `m_ready` in 1: master `report_ready`.
- `m_sent` in 1: master `report_send`.
- `init_done` out 1: high once the init sequence has completed.
- `busy` out 1: high when the state is not IDLE.
- `refresh_done` out 1: one-cycle pulse at the end of a frame.
- `refresh_drop` out 1: one-cycle pulse when a request is lost.

## Operation
- States: INIT, IDLE, WAIT_SENT, WAIT_READY. Registers: word index (3 bit), source (INIT/CMD/FRAME), refresh pending flag, digit/dp snapshot.
- Reset values: state=INIT, `m_cs`=1, `m_word`=0, `cmd_ack`=0, `init_done`=0, `refresh_done`=0, `refresh_drop`=0, pending=0, index=0. `busy` decodes the state, so it is 1 in reset.
- **Word issue:** on an edge where `m_ready`=1 and `m_sent`=0:
  - load `m_word`;
  - set `m_cs`=0;
  - go to WAIT_SENT.
- **WAIT_SENT:** hold `m_cs` low and `m_word` stable. When `m_sent`=1, set `m_cs`=1 and go to WAIT_READY.
- **WAIT_READY:** wait for `m_ready`=1 and `m_sent`=0. On that edge:
  - if the sequence has more words, issue the next word directly;
  - otherwise go to IDLE, and for a FRAME source pulse `refresh_done`.
- **INIT words, in order:**
  - 0x0C01
  - 0x09FF
  - {0x0B, 5'b0, SCAN_LIMIT}
  - {0x0A, 4'b0, INTENSITY}
  - 0x0F00
  - `init_done` is set on the completing WAIT_READY edge and stays high until reset.
- **Frame word k** (k=0..NUM_DIGITS-1): {k+1 (8 bit), dp[k], 3'b0, digit[k]}, sent in ascending k.
- **Snapshot:** `digits`/`dp_mask` are captured on the edge the frame's first word issues. Input changes mid-frame do not affect the frame.
- **Pending flag:**
  - set on any edge with `refresh_req`=1 while INIT, busy, or not yet granted;
  - if already set, pulse `refresh_drop` instead (one-deep queue);
  - cleared on frame grant.
- **Arbitration in IDLE**, with `m_ready`=1 and `m_sent`=0:
  - `cmd_req` has priority over pending refresh;
  - a cmd grant pulses `cmd_ack`, captures `cmd_word` and issues it in the same edge.
- Frames and commands are atomic: no preemption between words of a frame.
- `cmd_req` and `refresh_req` are not acted on during INIT; a refresh request is still latched into pending.
- Reset mid-operation: `m_cs` goes to 1 asynchronously, all state clears, and init replays after release.

## Timing
- Request to grant: `refresh_req` sampled at edge N sets pending at N; `m_cs` falls at edge N+1 if IDLE and `m_ready`=1.
- `cmd_req` sampled in IDLE with `m_ready`=1: `m_cs`=0 and `cmd_ack`=1 on the same edge.
- Inter-word gap equals the master's DONE→IDLE→ready turnaround. The scheduler adds 0 cycles after sampling ready.
- The scheduler never issues on the stale `m_ready` of the cycle it dropped `m_cs`, because it only samples ready in IDLE/WAIT_READY.
- `refresh_done` is asserted on the edge entering IDLE after the last frame word.

## Test plan
- Release `res` with a master model (ready idle, sent after 66 cycles) → words 0x0C01, 0x09FF, 0x0B05, 0x0A08, 0x0F00 in order. Each `m_cs` low spans until `m_sent`. `init_done` rises after the 5th.
- `digits`=24'h456789, `dp_mask`=6'b010100, pulse `refresh_req` → 0x0109, 0x0208, 0x0387, 0x0406, 0x0585, 0x0604, then one `refresh_done` pulse.
- In IDLE, raise `cmd_req` (0x0A0F) and `refresh_req` on the same edge → `cmd_ack` pulse and 0x0A0F sent first, then the full frame.
- Change `digits` to 24'h000000 after frame word 2 → remaining frame words still carry the snapshot values (0x0406, 0x0585, 0x0604).
- Pulse `refresh_req` twice during an active frame → `refresh_drop` on the second pulse; exactly one additional frame follows.
- Assert `res` while `m_cs`=0 mid-frame → `m_cs`=1 with no clock edge, `init_done`=0, `busy`=1. After release, the init sequence replays from 0x0C01.
